// File: rtl/mcu_link_queue_if.sv
// Source-channel and SPI-link signal bundle between mcu_link_queue (slave)
// and its frame sources / SPI slave (master).
interface mcu_link_queue_if #(
    parameter int NCH     = 4,
    parameter int FW      = 24,
    parameter int FIFO_AW = 9
);
    logic [NCH-1:0]    ch_req;
    logic [NCH*FW-1:0] ch_frame;
    logic [NCH-1:0]    ch_busy;
    logic [NCH-1:0]    drop_flags;
    logic [NCH-1:0]    drop_clr;
    logic [NCH-1:0]    ch_pause;
    logic              spi_di_req;
    logic [FW-1:0]     spi_di;
    logic              spi_do_valid;
    logic [FW-1:0]     spi_do;
    logic [FIFO_AW:0]  fifo_level;
    logic              link_alive;

    modport master (
        output ch_req, ch_frame, drop_clr, spi_di_req, spi_do_valid, spi_do,
        input  ch_busy, drop_flags, ch_pause, spi_di, fifo_level, link_alive
    );

    modport slave (
        input  ch_req, ch_frame, drop_clr, spi_di_req, spi_do_valid, spi_do,
        output ch_busy, drop_flags, ch_pause, spi_di, fifo_level, link_alive
    );
endinterface

// File: rtl/mcu_link_queue.sv
// Multi-channel transmit queue for the FPGA->MCU SPI link: per-channel holding
// slots, round-robin arbitration into a FWFT FIFO, NOP fill, flow control, watchdog.
module mcu_link_queue #(
    parameter int         NCH       = 4,
    parameter int         FW        = 24,
    parameter int         FIFO_AW   = 9,
    parameter logic [7:0] CMD_NOPE  = 8'hFF,
    parameter logic [7:0] CMD_FLOW  = 8'hF9,
    parameter int         TIMEOUT_W = 20
) (
    input logic             clk,
    input logic             reset,
    mcu_link_queue_if.slave lnk
);

    localparam int                   CW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int                   DEPTH      = 1 << FIFO_AW;
    localparam logic [FW-1:0]        NOP_FRAME  = {CMD_NOPE, {(FW-8){1'b0}}};
    localparam logic [FIFO_AW:0]     FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
    localparam logic [TIMEOUT_W-1:0] WD_MAX     = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST    = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    // Holding slots
    logic [FW-1:0]  slot_q [NCH];
    logic [NCH-1:0] busy_q;
    logic [NCH-1:0] drop_q;
    logic [NCH-1:0] pause_q;
    logic [NCH-1:0] slot_load;
    logic [NCH-1:0] slot_drop;

    // Arbiter
    logic [NCH-1:0] eligible;
    logic [NCH-1:0] grant_vec;
    logic [CW-1:0]  last_grant_q;
    logic [CW-1:0]  grant_idx;
    logic [CW-1:0]  cand;
    int             cand_sum;
    logic           grant_found;
    logic           grant_en;

    // FIFO
    logic [FW-1:0]      fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   level_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               nop_fill;
    logic               wrote_q;
    logic [FW-1:0]      push_data;

    // SPI side and watchdog
    logic                 req_q;
    logic                 di_rise;
    logic [FW-1:0]        spi_di_q;
    logic                 flow_cmd;
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic                 wd_hit;
    logic                 alive_q;
    logic                 unused_spi_do;

    assign eligible   = busy_q & ~pause_q;
    assign fifo_full  = (level_q == FULL_LEVEL);
    assign fifo_empty = (level_q == '0);

    // Rotating search starting just above the last granted channel.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = '0;
        cand_sum    = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand_sum = int'(last_grant_q) + k;
            if (cand_sum >= NCH) begin
                cand_sum = cand_sum - NCH;
            end
            cand = CW'(cand_sum);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_en = grant_found && !fifo_full;

    always_comb begin
        grant_vec = '0;
        slot_load = '0;
        slot_drop = '0;
        for (int i = 0; i < NCH; i++) begin
            grant_vec[i] = grant_en && (grant_idx == CW'(i));
            slot_load[i] = lnk.ch_req[i] && (!busy_q[i] || grant_vec[i]);
            slot_drop[i] = lnk.ch_req[i] && busy_q[i] && !grant_vec[i];
        end
    end

    assign nop_fill  = fifo_empty && !grant_en && !wrote_q;
    assign push      = grant_en || nop_fill;
    assign push_data = grant_en ? slot_q[grant_idx] : NOP_FRAME;
    assign di_rise   = lnk.spi_di_req && !req_q;
    assign pop       = di_rise && !fifo_empty;
    assign flow_cmd  = lnk.spi_do_valid && (lnk.spi_do[FW-1 -: 8] == CMD_FLOW);
    assign wd_hit    = !di_rise && (wd_cnt_q == WD_LAST);

    assign unused_spi_do = ^lnk.spi_do;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            busy_q       <= '0;
            drop_q       <= '0;
            last_grant_q <= CW'(NCH - 1);
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (slot_load[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    busy_q[i] <= 1'b0;
                end
                if (slot_drop[i]) begin
                    drop_q[i] <= 1'b1;
                end else if (lnk.drop_clr[i]) begin
                    drop_q[i] <= 1'b0;
                end
            end
            if (grant_en) begin
                last_grant_q <= grant_idx;
            end
        end
    end

    // NOTE: storage arrays carry no reset; their contents are meaningless
    // until written, and busy/level state already guards every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (slot_load[i]) begin
                slot_q[i] <= lnk.ch_frame[i*FW +: FW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wrote_q  <= 1'b0;
        end else begin
            wrote_q <= push;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // An empty FIFO on a word request still hands the MCU a NOP frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q    <= 1'b0;
            spi_di_q <= NOP_FRAME;
        end else begin
            req_q <= lnk.spi_di_req;
            if (di_rise) begin
                spi_di_q <= fifo_empty ? NOP_FRAME : fifo_mem[rd_ptr_q];
            end
        end
    end

    // Losing the link releases every paused channel so sources cannot stall forever.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_q  <= '0;
            wd_cnt_q <= '0;
            alive_q  <= 1'b0;
        end else begin
            if (wd_hit) begin
                pause_q <= '0;
            end else if (flow_cmd) begin
                pause_q <= lnk.spi_do[NCH-1:0];
            end
            if (di_rise) begin
                wd_cnt_q <= '0;
            end else if (wd_cnt_q != WD_MAX) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (di_rise) begin
                alive_q <= 1'b1;
            end else if (wd_hit) begin
                alive_q <= 1'b0;
            end
        end
    end

    assign lnk.ch_busy    = busy_q;
    assign lnk.drop_flags = drop_q;
    assign lnk.ch_pause   = pause_q;
    assign lnk.spi_di     = spi_di_q;
    assign lnk.fifo_level = level_q;
    assign lnk.link_alive = alive_q;

endmodule

// File: tb/tb_mcu_link_queue.sv
// Directed bench for mcu_link_queue: a scoreboard queue holds the expected FIFO
// order and is compared against spi_di on every word request.
module tb_mcu_link_queue;
    localparam int          NCH      = 4;
    localparam int          FW       = 24;
    localparam logic [23:0] NOP      = 24'hFF0000;
    localparam logic [7:0]  CMD_FLOW = 8'hF9;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [FW-1:0] exp_q [$];

    always #5 clk = ~clk;

    mcu_link_queue_if #(.NCH(NCH), .FW(FW), .FIFO_AW(2)) a_if ();
    mcu_link_queue_if #(.NCH(NCH), .FW(FW), .FIFO_AW(2)) w_if ();

    mcu_link_queue #(.NCH(NCH), .FW(FW), .FIFO_AW(2), .TIMEOUT_W(20)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .lnk   (a_if.slave)
    );

    mcu_link_queue #(.NCH(NCH), .FW(FW), .FIFO_AW(2), .TIMEOUT_W(4)) u_dut_w (
        .clk   (clk),
        .reset (reset),
        .lnk   (w_if.slave)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req_a(input logic [3:0] mask, input logic [23:0] base);
        for (int i = 0; i < NCH; i++) begin
            a_if.ch_frame[i*FW +: FW] = base | 24'(i);
        end
        a_if.ch_req = mask;
        step(1);
        a_if.ch_req = '0;
    endtask

    task automatic flow_a(input logic [7:0] cmd, input logic [15:0] payload);
        a_if.spi_do       = {cmd, payload};
        a_if.spi_do_valid = 1'b1;
        step(1);
        a_if.spi_do_valid = 1'b0;
        step(1);
    endtask

    task automatic pop_a(input string tag);
        logic [FW-1:0] exp;
        a_if.spi_di_req = 1'b1;
        step(1);
        a_if.spi_di_req = 1'b0;
        step(3);
        exp = (exp_q.size() == 0) ? NOP : exp_q.pop_front();
        check(tag, 32'(a_if.spi_di), 32'(exp));
        if (exp_q.size() == 0) exp_q.push_back(NOP);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_if.ch_req = '0;  a_if.ch_frame = '0; a_if.drop_clr = '0;
        a_if.spi_di_req = 1'b0; a_if.spi_do_valid = 1'b0; a_if.spi_do = '0;
        w_if.ch_req = '0;  w_if.ch_frame = '0; w_if.drop_clr = '0;
        w_if.spi_di_req = 1'b0; w_if.spi_do_valid = 1'b0; w_if.spi_do = '0;

        step(2);
        check("rst_busy",  32'(a_if.ch_busy),    0);
        check("rst_drop",  32'(a_if.drop_flags), 0);
        check("rst_pause", 32'(a_if.ch_pause),   0);
        check("rst_level", 32'(a_if.fifo_level), 0);
        check("rst_spi_di", 32'(a_if.spi_di),    32'(NOP));
        check("rst_alive", 32'(a_if.link_alive), 0);
        reset = 1'b0;
        step(3);
        check("nop_after_reset", 32'(a_if.fifo_level), 1);
        exp_q.push_back(NOP);

        // Round-robin: all four at once, ch3 waits for FIFO space.
        req_a(4'b1111, 24'h010000);
        for (int i = 0; i < NCH; i++) exp_q.push_back(24'h010000 | 24'(i));
        check("rr_busy_all", 32'(a_if.ch_busy), 32'hF);
        step(6);
        check("rr_full_level", 32'(a_if.fifo_level), 4);
        check("rr_ch3_waits", 32'(a_if.ch_busy), 32'h8);
        pop_a("rr_pop_nop");
        check("alive_after_edge", 32'(a_if.link_alive), 1);
        for (int i = 0; i < NCH; i++) pop_a("rr_pop_frame");

        // Wrap-around: last grant ch2, then ch3, ch0, ch1.
        req_a(4'b0100, 24'h020000);
        exp_q.push_back(24'h020002);
        step(3);
        req_a(4'b1011, 24'h020000);
        exp_q.push_back(24'h020003);
        exp_q.push_back(24'h020000);
        exp_q.push_back(24'h020001);
        step(6);
        check("wrap_level", 32'(a_if.fifo_level), 4);
        check("wrap_ch1_waits", 32'(a_if.ch_busy), 32'h2);
        for (int i = 0; i < 5; i++) pop_a("wrap_pop");

        // Drop on a paused, occupied slot.
        flow_a(CMD_FLOW, 16'h0004);
        check("drop_pause", 32'(a_if.ch_pause), 32'h4);
        req_a(4'b0100, 24'h030000);
        req_a(4'b0100, 24'h030B00);
        check("drop_flag_set", 32'(a_if.drop_flags), 32'h4);
        check("drop_busy", 32'(a_if.ch_busy), 32'h4);
        a_if.ch_frame[2*FW +: FW] = 24'h030C02;
        a_if.ch_req   = 4'b0100;
        a_if.drop_clr = 4'b0100;
        step(1);
        a_if.ch_req   = '0;
        a_if.drop_clr = '0;
        check("drop_set_wins", 32'(a_if.drop_flags), 32'h4);
        a_if.drop_clr = 4'b0100;
        step(1);
        a_if.drop_clr = '0;
        check("drop_clr", 32'(a_if.drop_flags), 0);
        flow_a(CMD_FLOW, 16'h0000);
        exp_q.push_back(24'h030002);
        step(3);
        pop_a("drop_pop_nop");
        pop_a("drop_first_kept");

        // Flow control: ch0/ch1 held, ch2 passes, unrelated command ignored.
        flow_a(CMD_FLOW, 16'h0003);
        check("flow_pause", 32'(a_if.ch_pause), 32'h3);
        req_a(4'b0111, 24'h040000);
        exp_q.push_back(24'h040002);
        step(4);
        check("flow_held", 32'(a_if.ch_busy), 32'h3);
        check("flow_level", 32'(a_if.fifo_level), 2);
        flow_a(8'h12, 16'h000F);
        check("flow_other_cmd", 32'(a_if.ch_pause), 32'h3);
        pop_a("flow_pop_nop");
        pop_a("flow_pop_ch2");
        check("flow_still_held", 32'(a_if.ch_busy), 32'h3);
        flow_a(CMD_FLOW, 16'h0000);
        exp_q.push_back(24'h040000);
        exp_q.push_back(24'h040001);
        step(3);
        for (int i = 0; i < 3; i++) pop_a("flow_drain");

        // Idle: only NOPs, at most one queued.
        for (int i = 0; i < 3; i++) begin
            pop_a("idle_nop");
            check("idle_level", 32'(a_if.fifo_level), 1);
        end

        // Full: NOP + 3 frames fill depth 4, three frames stay in slots.
        req_a(4'b1111, 24'h060000);
        exp_q.push_back(24'h060002);
        exp_q.push_back(24'h060003);
        exp_q.push_back(24'h060000);
        exp_q.push_back(24'h060001);
        step(4);
        req_a(4'b0101, 24'h06A000);
        exp_q.push_back(24'h06A002);
        exp_q.push_back(24'h06A000);
        step(4);
        check("full_level", 32'(a_if.fifo_level), 4);
        check("full_slots", 32'(a_if.ch_busy), 32'h7);
        pop_a("full_pop_nop");
        check("full_one_in_level", 32'(a_if.fifo_level), 4);
        check("full_one_in_slots", 32'(a_if.ch_busy), 32'h5);
        for (int i = 0; i < 6; i++) pop_a("full_drain");
        check("full_empty_slots", 32'(a_if.ch_busy), 0);

        // Request in the grant cycle is accepted, not dropped.
        req_a(4'b0001, 24'h080000);
        req_a(4'b0001, 24'h080100);
        exp_q.push_back(24'h080000);
        exp_q.push_back(24'h080100);
        check("grant_cycle_busy", 32'(a_if.ch_busy), 32'h1);
        check("grant_cycle_no_drop", 32'(a_if.drop_flags), 0);
        step(3);
        for (int i = 0; i < 3; i++) pop_a("grant_cycle_pop");

        // Watchdog (TIMEOUT_W=4 instance).
        w_if.spi_di_req = 1'b1;
        step(1);
        w_if.spi_di_req = 1'b0;
        step(2);
        check("wd_alive", 32'(w_if.link_alive), 1);
        check("wd_spi_di_nop", 32'(w_if.spi_di), 32'(NOP));
        w_if.spi_do = {CMD_FLOW, 16'h000F};
        w_if.spi_do_valid = 1'b1;
        step(1);
        w_if.spi_do_valid = 1'b0;
        step(1);
        check("wd_pause_set", 32'(w_if.ch_pause), 32'hF);
        step(5);
        check("wd_alive_mid", 32'(w_if.link_alive), 1);
        step(10);
        check("wd_alive_fell", 32'(w_if.link_alive), 0);
        check("wd_pause_clear", 32'(w_if.ch_pause), 0);
        w_if.spi_di_req = 1'b1;
        step(1);
        check("wd_alive_again", 32'(w_if.link_alive), 1);
        w_if.spi_di_req = 1'b0;
        step(2);

        // Asynchronous reset mid-operation.
        flow_a(CMD_FLOW, 16'h0001);
        req_a(4'b0001, 24'h070000);
        req_a(4'b0001, 24'h070100);
        check("pre_rst_busy", 32'(a_if.ch_busy), 32'h1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_busy",  32'(a_if.ch_busy),    0);
        check("arst_drop",  32'(a_if.drop_flags), 0);
        check("arst_pause", 32'(a_if.ch_pause),   0);
        check("arst_level", 32'(a_if.fifo_level), 0);
        check("arst_alive", 32'(a_if.link_alive), 0);
        step(2);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(NOP);
        step(3);
        check("arst_nop_level", 32'(a_if.fifo_level), 1);
        pop_a("arst_pop_nop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mcu_link_queue.md
# mcu_link_queue

Parametrised multi-channel transmit queue for the FPGA→MCU SPI link. It takes NCH independent frame sources (UART TX, RTC writes, debug, and future sources), holds one frame per channel and arbitrates between them round-robin into a shared FIFO. It presents the FIFO head to the SPI slave on each word request and fills the link with NOP frames when idle. It also adds per-channel flow control commanded by the MCU, sticky drop flags, and a link-alive watchdog.

## Interface
Parameters:
- NCH, 4: number of source channels (1..16).
- FW, 24: frame width; bits [FW-1:FW-8] are the command byte.
- FIFO_AW, 9: FIFO address width; depth = 2^FIFO_AW.
- CMD_NOPE, 8'hFF: command byte of the idle filler frame, which is {CMD_NOPE, zeros}.
- CMD_FLOW, 8'hF9: MCU→FPGA command carrying the pause mask.
- TIMEOUT_W, 20: watchdog counter width.

Ports:
- clk  in  1  system clock; the block uses this single clock.
- reset  in  1  asynchronous, active-high reset.
- ch_req  in  NCH  one-cycle request strobe per channel.
- ch_frame  in  NCH*FW  frame for channel i at [i*FW +: FW].
- ch_busy  out  NCH  channel holding slot is occupied.
- drop_flags  out  NCH  sticky: a request arrived while the slot was full.
- drop_clr  in  NCH  clears the matching drop_flags bits.
- ch_pause  out  NCH  pause mask set by the MCU.
- spi_di_req  in  1  word request level from the SPI slave.
- spi_di  out  FW  frame to be shifted out to the MCU.
- spi_do_valid  in  1  received frame strobe.
- spi_do  in  FW  received frame.
- fifo_level  out  FIFO_AW+1  FIFO occupancy.
- link_alive  out  1  at least one word request seen within the timeout window.

## Operation
- **Holding slots.** On ch_req[i] with slot i empty, latch the frame and set ch_busy[i]. On ch_req[i] with slot i full, discard the new frame and set drop_flags[i]. The one exception is the same cycle slot i is granted: the new frame is accepted and ch_busy[i] stays 1.
- **Drop flag priority.** When drop_clr[i] and a new drop occur in the same cycle, the set wins.
- **Arbiter.** A channel is eligible when ch_busy[i] & ~ch_pause[i]. When the FIFO is not full, grant the first eligible channel searching upward from last_grant+1 with wrap-around. At most one grant per cycle. last_grant resets to NCH-1, so channel 0 has first priority.
- **Granted channel.** Its frame is written to the FIFO and its slot is cleared at the end of the grant cycle.
- **NOP fill.** When fifo_level==0, no grant this cycle and no FIFO write in the previous cycle, write one NOP frame. This guarantees at most one NOP is queued at a time.
- **SPI load.** On a rising edge of spi_di_req (registered prev vs current):
  - FIFO non-empty: spi_di loads the FIFO head and the FIFO pops.
  - FIFO empty: spi_di loads the NOP frame and nothing pops.
- **Flow control.** On spi_do_valid with command byte == CMD_FLOW, ch_pause <= spi_do[NCH-1:0]. Paused channels keep their slots and keep dropping on overflow. All other commands are ignored by this block.
- **Watchdog.**
  - The counter clears on every spi_di_req rising edge and otherwise increments, saturating at all-ones.
  - link_alive = 1 from the cycle after an edge until the counter saturates.
  - On the saturation cycle, ch_pause clears to 0.
- **FIFO.** Internal, first-word-fall-through, depth 2^FIFO_AW, with a true occupancy counter.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - A push when full never happens, because grant and NOP fill are both blocked when full.

## Timing
- Reset values: ch_busy=0, drop_flags=0, ch_pause=0, spi_di={CMD_NOPE,0}, fifo_level=0, link_alive=0, last_grant=NCH-1, watchdog counter=0. FIFO contents and slot contents are discarded.
- Reset mid-operation clears everything immediately. The first NOP fill occurs 1 cycle after reset release.
- ch_req at cycle N → ch_busy high at N+1. Uncontended, the grant happens at N+1, the frame is in the FIFO and ch_busy is low at N+2, and fifo_level increments at N+2.
- spi_di_req rising between cycles k-1 and k → new spi_di valid at k+1, and fifo_level decrements at k+1.
- Full boundary: at fifo_level == 2^FIFO_AW, no grant is issued in that cycle even if a pop occurs; arbitration resumes the cycle after the level drops.
- Worst-case wait for an eligible channel once the FIFO has space: NCH-1 grant cycles.

## Test plan
- **Round-robin:** NCH=4, pulse ch_req on all four at once with frames 0x01_00_0i → FIFO order ch0, ch1, ch2, ch3; then a lone ch_req on ch1 with ch0 also pending → ch2 search order honoured (ch0 only after ch1).
- **Drop:** two ch_req on ch2 in consecutive cycles while ch_pause[2]=1 → second frame lost, drop_flags=4'b0100; drop_clr[2] → 0.
- **Flow:** spi_do={CMD_FLOW,16'h0003} with spi_do_valid → ch_pause=0011, ch0/ch1 frames held while ch2 frames pass; a CMD_FLOW frame with mask 0 → held frames drain in order ch0, ch1.
- **Idle/NOP:** no requests, 3 spi_di_req edges → spi_di = 0xFF0000 each time, fifo_level never above 1.
- **Full:** FIFO_AW=2, stall spi_di_req, queue 6 frames → fifo_level saturates at 4, remaining frames stay in slots with ch_busy=1; one pop → exactly one more frame enters.
- **Watchdog:** TIMEOUT_W=4, ch_pause=1111, no spi_di_req for 15 cycles → link_alive falls and ch_pause=0; the next edge → link_alive=1 one cycle later.
